// File: rtl/data_stream_checker_if.sv
// rtl/data_stream_checker_if.sv - control, data and status bundle of the multi-channel stream checker
interface data_stream_checker_if #(
   parameter int G_NB_CHECKER         = 2,
   parameter int G_CHECKER_DATA_WIDTH = 32,
   parameter int G_CNT_WIDTH          = 16
);
   localparam int N   = G_NB_CHECKER;
   localparam int W   = G_CHECKER_DATA_WIDTH;
   localparam int C   = G_CNT_WIDTH;
   localparam int CHW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   i_start;
   logic [N-1:0]   i_stop;
   logic [N-1:0]   i_clear;
   logic [N-1:0]   i_use_valid;
   logic           i_stop_on_error;
   logic [W-1:0]   i_mask;
   logic [N*W-1:0] i_exp_data;
   logic [N-1:0]   i_exp_wr;
   logic [N-1:0]   o_exp_full;
   logic [N*W-1:0] i_data;
   logic [N-1:0]   i_data_valid;
   logic [N-1:0]   o_busy;
   logic [N-1:0]   o_pass;
   logic [N-1:0]   o_fail;
   logic [N-1:0]   o_underflow;
   logic [N-1:0]   o_overflow;
   logic [N*C-1:0] o_ok_cnt;
   logic [N*C-1:0] o_err_cnt;
   logic           o_first_err_valid;
   logic [CHW-1:0] o_first_err_chan;
   logic [W-1:0]   o_first_err_data;
   logic [W-1:0]   o_first_err_exp;

   modport master (
      output i_start, i_stop, i_clear, i_use_valid, i_stop_on_error, i_mask,
             i_exp_data, i_exp_wr, i_data, i_data_valid,
      input  o_exp_full, o_busy, o_pass, o_fail, o_underflow, o_overflow,
             o_ok_cnt, o_err_cnt, o_first_err_valid, o_first_err_chan,
             o_first_err_data, o_first_err_exp
   );

   modport slave (
      input  i_start, i_stop, i_clear, i_use_valid, i_stop_on_error, i_mask,
             i_exp_data, i_exp_wr, i_data, i_data_valid,
      output o_exp_full, o_busy, o_pass, o_fail, o_underflow, o_overflow,
             o_ok_cnt, o_err_cnt, o_first_err_valid, o_first_err_chan,
             o_first_err_data, o_first_err_exp
   );
endinterface

// File: rtl/data_stream_checker.sv
// rtl/data_stream_checker.sv - per-channel expected-data FIFO compare with counters, sticky flags and first-error capture
module data_stream_checker #(
   parameter int G_NB_CHECKER         = 2,
   parameter int G_CHECKER_DATA_WIDTH = 32,
   parameter int G_FIFO_DEPTH         = 16,
   parameter int G_CNT_WIDTH          = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   data_stream_checker_if.slave bus
);
   localparam int N   = G_NB_CHECKER;
   localparam int W   = G_CHECKER_DATA_WIDTH;
   localparam int C   = G_CNT_WIDTH;
   localparam int AW  = $clog2(G_FIFO_DEPTH);
   localparam int CHW = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW:0] DEPTH_V = G_FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_HALT} state_t;

   logic [N-1:0]   err_ev;
   logic [N-1:0]   fifo_empty;
   logic [N*W-1:0] head_flat;

   for (genvar k = 0; k < N; k++) begin : g_chan
      state_t          state_q, state_d;
      logic [AW:0]     wr_ptr, rd_ptr, fill;
      logic [W-1:0]    mem [G_FIFO_DEPTH];
      logic [W-1:0]    obs, exp_w, head;
      logic            full, sample, pop, push, mismatch, underflow_ev;
      logic [C-1:0]    ok_cnt, err_cnt;
      logic            fail_q, und_q, ovf_q;

      assign obs   = bus.i_data[k*W +: W];
      assign exp_w = bus.i_exp_data[k*W +: W];
      assign fill  = wr_ptr - rd_ptr;
      assign full  = (fill == DEPTH_V);
      assign head  = mem[rd_ptr[AW-1:0]];
      assign fifo_empty[k]     = (fill == '0);
      assign head_flat[k*W +: W] = head;

      // A clear in the same cycle wins over any sample or push on this channel.
      assign sample = !bus.i_clear[k] && (state_q == S_RUN) &&
                      (bus.i_use_valid[k] ? bus.i_data_valid[k] : 1'b1);
      assign pop          = sample && !fifo_empty[k];
      assign push         = bus.i_exp_wr[k] && !full && !bus.i_clear[k];
      assign mismatch     = pop && (((obs ^ head) & bus.i_mask) != '0);
      assign underflow_ev = sample && fifo_empty[k];
      assign err_ev[k]    = mismatch || underflow_ev;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) state_q <= S_IDLE;
         else        state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         if (bus.i_clear[k]) begin
            state_d = S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: if (bus.i_start[k]) state_d = S_RUN;
               S_RUN: begin
                  if (err_ev[k] && bus.i_stop_on_error) state_d = S_HALT;
                  else if (bus.i_stop[k])              state_d = S_DONE;
               end
               S_DONE, S_HALT: if (bus.i_start[k]) state_d = S_RUN;
               default: state_d = S_IDLE;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr[AW-1:0]] <= exp_w;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ok_cnt  <= '0;
            err_cnt <= '0;
            fail_q  <= 1'b0;
            und_q   <= 1'b0;
            ovf_q   <= 1'b0;
         end else if (bus.i_clear[k]) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ok_cnt  <= '0;
            err_cnt <= '0;
            fail_q  <= 1'b0;
            und_q   <= 1'b0;
            ovf_q   <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (pop && !mismatch && ok_cnt != '1) ok_cnt <= ok_cnt + 1'b1;
            if (err_ev[k] && err_cnt != '1)       err_cnt <= err_cnt + 1'b1;
            if (err_ev[k])                        fail_q <= 1'b1;
            if (underflow_ev)                     und_q  <= 1'b1;
            if (bus.i_exp_wr[k] && full)          ovf_q  <= 1'b1;
         end
      end

      assign bus.o_exp_full[k]     = full;
      assign bus.o_busy[k]         = (state_q == S_RUN);
      assign bus.o_pass[k]         = (state_q == S_DONE) && (err_cnt == '0) && fifo_empty[k];
      assign bus.o_fail[k]         = fail_q;
      assign bus.o_underflow[k]    = und_q;
      assign bus.o_overflow[k]     = ovf_q;
      assign bus.o_ok_cnt[k*C +: C]  = ok_cnt;
      assign bus.o_err_cnt[k*C +: C] = err_cnt;
   end

   logic           cap_valid;
   logic [CHW-1:0] cap_chan;
   logic [W-1:0]   cap_data, cap_exp;
   logic [CHW-1:0] err_chan;
   logic [W-1:0]   err_data, err_exp;
   logic           cap_release;

   // Scan from the top so the lowest erroring channel is the one left selected.
   always_comb begin
      err_chan = '0;
      err_data = '0;
      err_exp  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (err_ev[k]) begin
            err_chan = CHW'(k);
            err_data = bus.i_data[k*W +: W];
            err_exp  = fifo_empty[k] ? '0 : head_flat[k*W +: W];
         end
      end
   end

   assign cap_release = cap_valid && bus.i_clear[cap_chan];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid <= 1'b0;
         cap_chan  <= '0;
         cap_data  <= '0;
         cap_exp   <= '0;
      end else begin
         if (cap_release) begin
            cap_valid <= 1'b0;
            cap_chan  <= '0;
            cap_data  <= '0;
            cap_exp   <= '0;
         end
         if ((!cap_valid || cap_release) && (|err_ev)) begin
            cap_valid <= 1'b1;
            cap_chan  <= err_chan;
            cap_data  <= err_data;
            cap_exp   <= err_exp;
         end
      end
   end

   assign bus.o_first_err_valid = cap_valid;
   assign bus.o_first_err_chan  = cap_chan;
   assign bus.o_first_err_data  = cap_data;
   assign bus.o_first_err_exp   = cap_exp;
endmodule

// File: tb/tb_data_stream_checker.sv
// tb/tb_data_stream_checker.sv - scoreboard bench for data_stream_checker with directed vectors
module tb_data_stream_checker;
   localparam int N = 2;
   localparam int W = 32;
   localparam int D = 16;
   localparam int C = 4;

   logic clk;
   logic rst_n;

   data_stream_checker_if #(.G_NB_CHECKER(N), .G_CHECKER_DATA_WIDTH(W), .G_CNT_WIDTH(C)) bus ();

   data_stream_checker #(
      .G_NB_CHECKER(N), .G_CHECKER_DATA_WIDTH(W), .G_FIFO_DEPTH(D), .G_CNT_WIDTH(C)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {F_OK, F_ERR, F_PASS, F_FAIL, F_UND, F_OVF, F_FULL, F_BUSY,
                 F_FEV, F_FCH, F_FDATA, F_FEXP} field_t;
   typedef struct {
      string       name;
      field_t      f;
      int          ch;
      logic [31:0] val;
   } chk_t;

   chk_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic logic [31:0] actual(field_t f, int ch);
      case (f)
         F_OK:    return 32'(bus.o_ok_cnt[ch*C +: C]);
         F_ERR:   return 32'(bus.o_err_cnt[ch*C +: C]);
         F_PASS:  return 32'(bus.o_pass[ch]);
         F_FAIL:  return 32'(bus.o_fail[ch]);
         F_UND:   return 32'(bus.o_underflow[ch]);
         F_OVF:   return 32'(bus.o_overflow[ch]);
         F_FULL:  return 32'(bus.o_exp_full[ch]);
         F_BUSY:  return 32'(bus.o_busy[ch]);
         F_FEV:   return 32'(bus.o_first_err_valid);
         F_FCH:   return 32'(bus.o_first_err_chan);
         F_FDATA: return bus.o_first_err_data;
         default: return bus.o_first_err_exp;
      endcase
   endfunction

   task automatic expect_v(string name, field_t f, int ch, logic [31:0] v);
      chk_t c;
      c.name = name;
      c.f    = f;
      c.ch   = ch;
      c.val  = v;
      sb.push_back(c);
   endtask

   // Monitor: drains pending expectations against the DUT away from the active edge.
   always @(negedge clk) begin
      chk_t        c;
      logic [31:0] a;
      while (sb.size() > 0) begin
         c = sb.pop_front();
         a = actual(c.f, c.ch);
         n_checks++;
         if (a === c.val) n_pass++;
         else $display("FAIL %s ch%0d: actual %0h required %0h", c.name, c.ch, a, c.val);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(int ch, logic [31:0] v);
      bus.i_exp_data[ch*W +: W] = v;
      bus.i_exp_wr[ch] = 1'b1;
      tick();
      bus.i_exp_wr[ch] = 1'b0;
   endtask

   task automatic sample_v(int ch, logic [31:0] v);
      bus.i_data[ch*W +: W] = v;
      bus.i_data_valid[ch] = 1'b1;
      tick();
      bus.i_data_valid[ch] = 1'b0;
   endtask

   task automatic pulse_start(logic [N-1:0] m);
      bus.i_start = m;
      tick();
      bus.i_start = '0;
   endtask

   task automatic pulse_clear(logic [N-1:0] m);
      bus.i_clear = m;
      tick();
      bus.i_clear = '0;
   endtask

   initial begin
      rst_n               = 1'b0;
      bus.i_start         = '0;
      bus.i_stop          = '0;
      bus.i_clear         = '0;
      bus.i_use_valid     = '0;
      bus.i_stop_on_error = 1'b0;
      bus.i_mask          = 32'hFFFF_FFFF;
      bus.i_exp_data      = '0;
      bus.i_exp_wr        = '0;
      bus.i_data          = '0;
      bus.i_data_valid    = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      for (int ch = 0; ch < N; ch++) begin
         expect_v("rst_ok", F_OK, ch, 0);
         expect_v("rst_err", F_ERR, ch, 0);
         expect_v("rst_pass", F_PASS, ch, 0);
         expect_v("rst_fail", F_FAIL, ch, 0);
         expect_v("rst_und", F_UND, ch, 0);
         expect_v("rst_ovf", F_OVF, ch, 0);
         expect_v("rst_full", F_FULL, ch, 0);
         expect_v("rst_busy", F_BUSY, ch, 0);
      end
      expect_v("rst_fev", F_FEV, 0, 0);
      expect_v("rst_fch", F_FCH, 0, 0);
      expect_v("rst_fdata", F_FDATA, 0, 0);
      expect_v("rst_fexp", F_FEXP, 0, 0);
      tick();

      // Free-running compare on ch0
      push(0, 1); push(0, 2); push(0, 3);
      bus.i_start = 2'b01;
      tick();
      bus.i_start = '0;
      bus.i_data[0 +: W] = 1;
      expect_v("t1_busy", F_BUSY, 0, 1);
      tick();
      bus.i_data[0 +: W] = 2;
      tick();
      bus.i_data[0 +: W] = 3;
      bus.i_stop = 2'b01;
      tick();
      bus.i_stop = '0;
      expect_v("t1_ok", F_OK, 0, 3);
      expect_v("t1_err", F_ERR, 0, 0);
      expect_v("t1_pass", F_PASS, 0, 1);
      expect_v("t1_busy_off", F_BUSY, 0, 0);
      expect_v("t1_fail", F_FAIL, 0, 0);
      tick();

      // Valid-qualified compare with mask on ch1
      bus.i_use_valid = 2'b10;
      push(1, 32'hA5A5_0000);
      pulse_start(2'b10);
      bus.i_mask = 32'hFFFF_FF00;
      sample_v(1, 32'hA5A5_00FF);
      expect_v("t2_ok_masked", F_OK, 1, 1);
      expect_v("t2_err_masked", F_ERR, 1, 0);
      expect_v("t2_fev_masked", F_FEV, 0, 0);
      push(1, 32'hA5A5_0000);
      bus.i_mask = 32'hFFFF_FFFF;
      sample_v(1, 32'hA5A5_00FF);
      expect_v("t2_err", F_ERR, 1, 1);
      expect_v("t2_fail", F_FAIL, 1, 1);
      expect_v("t2_fev", F_FEV, 0, 1);
      expect_v("t2_fch", F_FCH, 0, 1);
      expect_v("t2_fexp", F_FEXP, 0, 32'hA5A5_0000);
      expect_v("t2_fdata", F_FDATA, 0, 32'hA5A5_00FF);
      tick();

      // Simultaneous errors: lowest channel wins, later errors ignored
      pulse_clear(2'b10);
      expect_v("t3_fev_released", F_FEV, 0, 0);
      expect_v("t3_err1_cleared", F_ERR, 1, 0);
      bus.i_use_valid = 2'b11;
      bus.i_exp_data = {32'h20, 32'h10};
      bus.i_exp_wr = 2'b11;
      tick();
      bus.i_exp_wr = '0;
      pulse_start(2'b11);
      bus.i_data = {32'h21, 32'h11};
      bus.i_data_valid = 2'b11;
      tick();
      bus.i_data_valid = '0;
      expect_v("t3_fev", F_FEV, 0, 1);
      expect_v("t3_fch", F_FCH, 0, 0);
      expect_v("t3_fdata", F_FDATA, 0, 32'h11);
      expect_v("t3_fexp", F_FEXP, 0, 32'h10);
      expect_v("t3_err0", F_ERR, 0, 1);
      expect_v("t3_err1", F_ERR, 1, 1);
      expect_v("t3_ok0_kept", F_OK, 0, 3);
      push(1, 32'h30);
      sample_v(1, 32'h31);
      expect_v("t3_err1_later", F_ERR, 1, 2);
      expect_v("t3_fch_held", F_FCH, 0, 0);
      expect_v("t3_fdata_held", F_FDATA, 0, 32'h11);
      tick();

      // Stop on error into HALT
      pulse_clear(2'b11);
      expect_v("t4_fev_cleared", F_FEV, 0, 0);
      expect_v("t4_ok_cleared", F_OK, 0, 0);
      bus.i_stop_on_error = 1'b1;
      push(0, 5); push(0, 6); push(0, 7);
      pulse_start(2'b01);
      sample_v(0, 5);
      sample_v(0, 9);
      expect_v("t4_halt_busy", F_BUSY, 0, 0);
      expect_v("t4_ok", F_OK, 0, 1);
      expect_v("t4_err", F_ERR, 0, 1);
      expect_v("t4_fail", F_FAIL, 0, 1);
      expect_v("t4_fdata", F_FDATA, 0, 9);
      expect_v("t4_fexp", F_FEXP, 0, 6);
      sample_v(0, 7);
      expect_v("t4_halt_ok", F_OK, 0, 1);
      expect_v("t4_halt_err", F_ERR, 0, 1);
      bus.i_stop_on_error = 1'b0;
      pulse_start(2'b01);
      sample_v(0, 7);
      expect_v("t4_resume_ok", F_OK, 0, 2);
      expect_v("t4_resume_und", F_UND, 0, 0);
      sample_v(0, 0);
      expect_v("t4_drained_und", F_UND, 0, 1);
      expect_v("t4_drained_err", F_ERR, 0, 2);
      tick();

      // FIFO full, overflow, clear-drops-push, underflow capture
      pulse_clear(2'b11);
      for (int i = 0; i < D; i++) begin
         push(1, 32'(i));
         if (i == D - 2) expect_v("t5_not_full", F_FULL, 1, 0);
      end
      expect_v("t5_full", F_FULL, 1, 1);
      expect_v("t5_no_ovf", F_OVF, 1, 0);
      push(1, 32'hFF);
      expect_v("t5_ovf", F_OVF, 1, 1);
      expect_v("t5_still_full", F_FULL, 1, 1);
      bus.i_exp_wr = 2'b10;
      bus.i_clear  = 2'b10;
      tick();
      bus.i_exp_wr = '0;
      bus.i_clear  = '0;
      expect_v("t5_clr_full", F_FULL, 1, 0);
      expect_v("t5_clr_ovf", F_OVF, 1, 0);
      pulse_start(2'b10);
      sample_v(1, 32'hDEAD);
      expect_v("t5_und", F_UND, 1, 1);
      expect_v("t5_fail", F_FAIL, 1, 1);
      expect_v("t5_err", F_ERR, 1, 1);
      expect_v("t5_fev", F_FEV, 0, 1);
      expect_v("t5_fch", F_FCH, 0, 1);
      expect_v("t5_fdata", F_FDATA, 0, 32'hDEAD);
      expect_v("t5_fexp", F_FEXP, 0, 0);
      tick();

      // Saturation at 2^C-1, then asynchronous reset during RUN
      pulse_clear(2'b11);
      bus.i_use_valid = 2'b00;
      for (int i = 0; i < D; i++) push(0, 0);
      bus.i_data[0 +: W] = 1;
      pulse_start(2'b01);
      repeat (14) tick();
      expect_v("t6_err14", F_ERR, 0, 14);
      repeat (6) tick();
      expect_v("t6_err_sat", F_ERR, 0, 15);
      expect_v("t6_ok", F_OK, 0, 0);
      expect_v("t6_und", F_UND, 0, 1);
      expect_v("t6_busy", F_BUSY, 0, 1);
      tick();
      rst_n = 1'b0;
      expect_v("t6_arst_busy", F_BUSY, 0, 0);
      expect_v("t6_arst_err", F_ERR, 0, 0);
      expect_v("t6_arst_und", F_UND, 0, 0);
      expect_v("t6_arst_fail", F_FAIL, 0, 0);
      expect_v("t6_arst_full", F_FULL, 0, 0);
      expect_v("t6_arst_fev", F_FEV, 0, 0);
      expect_v("t6_arst_fdata", F_FDATA, 0, 0);
      expect_v("t6_arst_fexp", F_FEXP, 0, 0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL sb_drain: actual %0d pending required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/data_stream_checker.md
# data_stream_checker

Multi-channel, self-checking data comparator for the testbench library. Each channel holds a FIFO of expected words loaded by the bench, compares observed DUT data against it with a bit mask, and keeps saturating OK/error counters, sticky status flags and a global first-error capture. Sampling can be free-running every cycle or qualified by a per-channel valid. It is fully synthesizable, so the same checker also runs in emulation and in standalone benches.

## Interface
- G_NB_CHECKER, 2: number of independent channels (≥1)
- G_CHECKER_DATA_WIDTH, 32: data width W per channel
- G_FIFO_DEPTH, 16: expected-data FIFO depth per channel (power of 2, ≥2)
- G_CNT_WIDTH, 16: width C of the OK and error counters

Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  N  per channel: IDLE→RUN
- i_stop  in  N  per channel: RUN→DONE
- i_clear  in  N  per channel: synchronous clear of FIFO, counters, flags; →IDLE
- i_use_valid  in  N  1: sample only when i_data_valid; 0: sample every RUN cycle
- i_stop_on_error  in  1  1: first mismatch moves channel to HALT
- i_mask  in  W  compare mask shared by all channels (1 = bit compared)
- i_exp_data  in  N*W  expected word, channel k at [k*W +: W]
- i_exp_wr  in  N  push i_exp_data slice into channel FIFO
- o_exp_full  out  N  FIFO full
- i_data  in  N*W  observed data, channel k at [k*W +: W]
- i_data_valid  in  N  observed data qualifier
- o_busy  out  N  channel in RUN
- o_pass  out  N  DONE, zero errors, FIFO empty
- o_fail  out  N  sticky: any error since clear
- o_underflow  out  N  sticky: sample with empty FIFO
- o_overflow  out  N  sticky: push while full
- o_ok_cnt  out  N*C  matched samples
- o_err_cnt  out  N*C  mismatches plus underflows
- o_first_err_valid  out  1  first-error capture holds data
- o_first_err_chan  out  $clog2(N) (min 1)  channel of first error
- o_first_err_data  out  W  observed word at first error
- o_first_err_exp  out  W  expected word at first error (0 on underflow)

## Operation
- Per-channel FSM: IDLE, RUN, DONE, HALT. IDLE→RUN on i_start; RUN→DONE on i_stop; RUN→HALT on an error when i_stop_on_error=1; DONE/HALT→RUN on i_start (counters kept); any state→IDLE on i_clear (priority over start/stop).
- Sample event (RUN only): i_use_valid ? i_data_valid : 1. No sampling in IDLE, DONE, HALT.
- On sample with FIFO non-empty: pop head; match if ((i_data ^ head) & i_mask) == 0 → o_ok_cnt+1, else o_err_cnt+1 and o_fail=1.
- On sample with FIFO empty: o_err_cnt+1, o_underflow=1, o_fail=1; no pop.
- FIFO push: i_exp_wr accepted in any state when not full; push while full is dropped and sets o_overflow. No bypass: push and sample in the same cycle on an empty FIFO counts as underflow, and the pushed word is stored.
- Counters saturate at 2^C−1 and never wrap.
- First-error capture: loaded on the first error of any channel after reset; the lowest channel index wins on simultaneous errors. Held until rst_n or until i_clear of the captured channel.
- o_pass = (state==DONE) & err_cnt==0 & FIFO empty; combinational from registers.

## Timing
- Reset: FSM IDLE; FIFOs empty; all counters 0; o_busy, o_pass, o_fail, o_underflow, o_overflow, o_exp_full, o_first_err_valid 0; capture fields 0.
- Sample on edge T updates counters, flags and capture, visible after T. The pop takes effect at T; the next sample at T+1 compares the next word.
- i_start at edge T: o_busy=1 after T; the first sample is possible at T+1.
- i_stop at T: a sample presented at T is still checked; o_busy=0 after T.
- HALT: the error sample at T is counted; state is HALT after T; no further samples.
- o_exp_full updates the cycle after the push that fills the FIFO; a same-cycle pop and push on a full FIFO drops the push (full is checked pre-pop).
- i_clear at T: all channel state is reset after T; a push at T is dropped.

## Test plan
- Ch0 load 0x1,0x2,0x3; i_use_valid=0; start; drive 1,2,3; stop → ok_cnt=3, err_cnt=0, o_pass=1.
- Ch1 i_use_valid=1; load 0xA5A5_0000; valid pulse with data 0xA5A5_00FF, mask 0xFFFF_FF00 → ok_cnt=1; same case with mask 0xFFFF_FFFF → err_cnt=1, o_first_err_chan=1, exp=0xA5A5_0000.
- Both channels mismatch on the same edge → o_first_err_chan=0; a later ch1 error leaves the capture unchanged.
- i_stop_on_error=1; expected 5,6,7, observed 5,9,7 → state HALT after the 2nd sample, ok_cnt=1, err_cnt=1, FIFO holds one word.
- Push 17 words with depth 16 → o_exp_full=1 after the 16th push, o_overflow=1; sample with empty FIFO → o_underflow=1, capture exp=0.
- C=4: 20 mismatches → err_cnt stays at 15; assert rst_n low during RUN → all outputs return to reset values immediately.
